// File: rtl/alu_seq.sv
// Multicycle 4-bit ALU with a start/done handshake. Multiply (shift-add) and
// divide/modulo (restoring) iterate over four cycles; all other ops take one.
module alu_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] op,
  output logic [3:0] y,
  output logic [4:0] f,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3, OP_MOD = 4'd4,
    OP_AND = 4'd5, OP_OR  = 4'd6, OP_XOR = 4'd7, OP_SHL = 4'd8, OP_SHR = 4'd9
  } op_t;

  state_t     state, state_nx;
  op_t        op_in, op_r;
  logic [3:0] a_r, b_r;
  logic [2:0] cnt;
  logic [7:0] prod;
  logic [3:0] rem, quo;
  logic       accept, multi;

  logic [4:0] mul_sum, div_trial, div_sub;
  logic       div_ge;
  logic [4:0] sum5, diff5;
  logic [3:0] res_y;
  logic       res_c, res_v, res_e;

  assign op_in = op_t'(op);
  assign multi = ((op_in == OP_MUL) || (op_in == OP_DIV) || (op_in == OP_MOD)) && (b != '0);
  assign busy  = (state == EXEC);
  assign done  = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept   = 1'b1;
        state_nx = EXEC;
      end
      EXEC: if (cnt == '0) state_nx = DONE;
      DONE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = EXEC;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // One shift-add step on {acc, multiplier}; one restoring-division step on {rem, quo}
  always_comb begin
    mul_sum   = {1'b0, prod[7:4]} + (prod[0] ? {1'b0, a_r} : 5'd0);
    div_trial = {rem, quo[3]};
    div_ge    = (div_trial >= {1'b0, b_r});
    div_sub   = div_trial - {1'b0, b_r};
  end

  always_comb begin
    sum5  = {1'b0, a_r} + {1'b0, b_r};
    diff5 = {1'b0, a_r} - {1'b0, b_r};
    res_y = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    res_e = 1'b0;
    case (op_r)
      OP_ADD: begin
        res_y = sum5[3:0];
        res_c = sum5[4];
        res_v = (a_r[3] == b_r[3]) && (sum5[3] != a_r[3]);
      end
      OP_SUB: begin
        res_y = diff5[3:0];
        res_c = diff5[4];
        res_v = (a_r[3] != b_r[3]) && (diff5[3] != a_r[3]);
      end
      OP_MUL: begin
        res_y = prod[3:0];
        res_c = (prod[7:4] != '0);
      end
      OP_DIV: begin
        if (b_r == '0) res_e = 1'b1;
        else           res_y = quo;
      end
      OP_MOD: begin
        if (b_r == '0) res_e = 1'b1;
        else           res_y = rem;
      end
      OP_AND: res_y = a_r & b_r;
      OP_OR:  res_y = a_r | b_r;
      OP_XOR: res_y = a_r ^ b_r;
      OP_SHL: begin
        res_y = {a_r[2:0], 1'b0};
        res_c = a_r[3];
      end
      OP_SHR: begin
        res_y = {1'b0, a_r[3:1]};
        res_c = a_r[0];
      end
      default: res_e = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y    <= '0;
      f    <= '0;
      cnt  <= '0;
      a_r  <= '0;
      b_r  <= '0;
      op_r <= OP_ADD;
      prod <= '0;
      rem  <= '0;
      quo  <= '0;
    end else if (accept) begin
      a_r  <= a;
      b_r  <= b;
      op_r <= op_in;
      cnt  <= multi ? 3'd4 : 3'd0;
      prod <= {4'b0000, b};
      rem  <= '0;
      quo  <= a;
    end else if (state == EXEC) begin
      if (cnt != '0) begin
        // Both iterators advance every step; only the one matching op_r is used
        prod <= {mul_sum, prod[3:1]};
        rem  <= div_ge ? div_sub[3:0] : div_trial[3:0];
        quo  <= {quo[2:0], div_ge};
        cnt  <= cnt - 3'd1;
      end else begin
        y <= res_y;
        f <= {res_y[3], (res_y == '0), res_c, res_v, res_e};
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes expected results and done
// timing; a negedge monitor pops and compares on every done pulse.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a = '0, b = '0, op = '0;
  logic [3:0] y;
  logic [4:0] f;
  logic       busy, done;

  alu_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .op(op),
    .y(y), .f(f), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] y;
    logic [4:0] f;
    int         acc;
    int         due;
  } exp_t;

  exp_t q[$];
  int   ncnt = 0;
  int   errors = 0;
  int   checks = 0;

  always @(negedge clk) begin
    exp_t e;
    ncnt++;
    if (done) begin
      checks++;
      if (busy) begin
        errors++;
        $display("FAIL busy_at_done: busy=%b required 0 (cycle %0d)", busy, ncnt);
      end
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: y=%b f=%b at cycle %0d", y, f, ncnt);
      end else begin
        e = q.pop_front();
        checks += 3;
        if (y !== e.y) begin
          errors++;
          $display("FAIL result_y: got %b required %b (cycle %0d)", y, e.y, ncnt);
        end
        if (f !== e.f) begin
          errors++;
          $display("FAIL flags_f: got %b required %b (cycle %0d)", f, e.f, ncnt);
        end
        if (ncnt != e.due) begin
          errors++;
          $display("FAIL done_timing: got cycle %0d required %0d", ncnt, e.due);
        end
      end
    end else if (q.size() > 0 && ncnt > q[0].acc && ncnt < q[0].due) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_exec: got %b required 1 (cycle %0d)", busy, ncnt);
      end
    end
  end

  task automatic push(input logic [3:0] ey, input logic [4:0] ef, input int acc, input int lat);
    exp_t e;
    e.y = ey; e.f = ef; e.acc = acc; e.due = acc + lat;
    q.push_back(e);
  endtask

  task automatic issue(input logic [3:0] ta, input logic [3:0] tb_v, input logic [3:0] top,
                       input logic [3:0] ey, input logic [4:0] ef, input int lat,
                       input bit expect_done);
    @(negedge clk); #1;
    a = ta; b = tb_v; op = top; start = 1'b1;
    if (expect_done) push(ey, ef, ncnt, lat);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (q.size() != 0 && k < 30) begin
      @(negedge clk); #1;
      k++;
    end
    if (q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL done_timeout: %0d results outstanding, required 0", q.size());
      q.delete();
    end
    @(negedge clk); #1;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (y !== 4'b0000 || f !== 5'b00000 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s: y=%b f=%b busy=%b done=%b required 0000 00000 0 0",
               name, y, f, busy, done);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_zero("reset_state");
    rst = 1'b0;

    issue(4'b1011, 4'b0011, 4'b0000, 4'b1110, 5'b10000, 2, 1'b1); wait_idle();
    issue(4'b0111, 4'b0001, 4'b0000, 4'b1000, 5'b10010, 2, 1'b1); wait_idle();
    issue(4'b0011, 4'b0101, 4'b0001, 4'b1110, 5'b10100, 2, 1'b1); wait_idle();
    issue(4'b1011, 4'b0011, 4'b0111, 4'b1000, 5'b10000, 2, 1'b1); wait_idle();

    // Multiply while start toggles and operands change during execution
    issue(4'b1011, 4'b0011, 4'b0010, 4'b0001, 5'b00100, 6, 1'b1);
    @(posedge clk); #1; a = 4'b0000; b = 4'b0001; op = 4'b0000; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; a = 4'b1111; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_idle();

    issue(4'b1011, 4'b0011, 4'b0011, 4'b0011, 5'b00000, 6, 1'b1); wait_idle();
    issue(4'b1011, 4'b0011, 4'b0100, 4'b0010, 5'b00000, 6, 1'b1); wait_idle();
    issue(4'b1011, 4'b0000, 4'b0011, 4'b0000, 5'b01001, 2, 1'b1); wait_idle();
    issue(4'b1011, 4'b0000, 4'b1000, 4'b0110, 5'b00100, 2, 1'b1); wait_idle();
    issue(4'b1011, 4'b0000, 4'b1001, 4'b0101, 5'b00100, 2, 1'b1); wait_idle();
    issue(4'b1011, 4'b0011, 4'b1100, 4'b0000, 5'b01001, 2, 1'b1); wait_idle();

    // Back-to-back subtract: start held through the first done cycle
    @(negedge clk); #1;
    a = 4'b1011; b = 4'b0011; op = 4'b0001; start = 1'b1;
    push(4'b1000, 5'b10000, ncnt, 2);
    push(4'b1000, 5'b10000, ncnt + 2, 2);
    repeat (3) @(negedge clk);
    #1 start = 1'b0;
    wait_idle();

    // Reset asserted at the third edge of a multiply aborts it silently
    issue(4'b1011, 4'b0011, 4'b0010, 4'b0000, 5'b00000, 6, 1'b0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk); #1;
    check_zero("reset_abort");
    rst = 1'b0;
    repeat (8) @(negedge clk);

    issue(4'b0001, 4'b0001, 4'b0000, 4'b0010, 5'b00000, 2, 1'b1); wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
